layer_draw_sequencer: RTL and testbench

Frame-level controller sitting directly downstream of the background, window and sprite layer drawers. On each frame trigger it starts the enabled drawers one at a time using their start/done handshake. It accepts the active drawer's pixel stream, maps the 2-bit colour index through the matching palette register, and issues single-cycle writes into the 160x144 VGA frame buffer.

---
 rtl/layer_draw_sequencer_if.sv | 53 +++++
 rtl/layer_draw_sequencer.sv | 157 +++++++++++++++
 tb/tb_layer_draw_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_draw_sequencer_if.sv
// Bus between the layer draw sequencer, its three layer drawers and the frame buffer.
//
// Drawer side (bit 0 bg, bit 1 window, bit 2 sprite; the multi-bit fields are packed
// {obj, win, bg}):
//   layer_start  3   start request to each drawer
//   layer_done   3   done from each drawer
//   layer_draw   3   per-drawer pixel-valid strobe
//   layer_x      24  x coordinate, 8 bits per drawer
//   layer_y      24  y coordinate, 8 bits per drawer
//   layer_color  6   2-bit colour index per drawer
// Frame buffer side:
//   fb_we        1       single-cycle write enable
//   fb_addr      ADDR_W  write address (y*FB_W + x)
//   fb_data      2       shade
//
// master: the sequencer.  slave: drawers plus frame buffer.
interface layer_draw_sequencer_if #(
  parameter int unsigned ADDR_W = 15
);
  logic [2:0]        layer_start;
  logic [2:0]        layer_done;
  logic [2:0]        layer_draw;
  logic [23:0]       layer_x;
  logic [23:0]       layer_y;
  logic [5:0]        layer_color;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [1:0]        fb_data;

  modport master (
    output layer_start,
    output fb_we,
    output fb_addr,
    output fb_data,
    input  layer_done,
    input  layer_draw,
    input  layer_x,
    input  layer_y,
    input  layer_color
  );

  modport slave (
    input  layer_start,
    input  fb_we,
    input  fb_addr,
    input  fb_data,
    output layer_done,
    output layer_draw,
    output layer_x,
    output layer_y,
    output layer_color
  );
endinterface

// File: rtl/layer_draw_sequencer.sv
// Frame-level controller for the bg, window and sprite layer drawers.
//
// On frame_start_i (only honoured when idle) it runs each enabled drawer in the fixed
// order bg, window, sprite using a start/done handshake. Pixels from the drawer that is
// currently running are mapped through its palette and written to the 160x144 frame
// buffer through one register stage.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   frame_start_i   one-cycle pulse that begins a frame
//   bg_en_i, win_en_i, obj_en_i   layer enables, sampled as each layer is reached
//   bgp_i, obp_i    palettes (bg/window, sprite); index i -> pal[2i+1:2i]
//   bus             drawer handshake, pixel streams and frame buffer write port
//   busy_o          high in every state except idle
//   frame_done_o    one-cycle pulse when the frame is complete
module layer_draw_sequencer #(
  parameter int unsigned FB_W   = 160,
  parameter int unsigned FB_H   = 144,
  parameter int unsigned ADDR_W = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start_i,
  input  logic                          bg_en_i,
  input  logic                          win_en_i,
  input  logic                          obj_en_i,
  input  logic [7:0]                    bgp_i,
  input  logic [7:0]                    obp_i,
  layer_draw_sequencer_if.master        bus,
  output logic                          busy_o,
  output logic                          frame_done_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRunBg  = 3'd1;
  localparam logic [2:0] StRelBg  = 3'd2;
  localparam logic [2:0] StRunWin = 3'd3;
  localparam logic [2:0] StRelWin = 3'd4;
  localparam logic [2:0] StRunObj = 3'd5;
  localparam logic [2:0] StRelObj = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [2:0]        layer_start_q, layer_start_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [1:0]        fb_data_q, fb_data_d;

  function automatic logic [1:0] shade_of(input logic [7:0] pal, input logic [1:0] c);
    logic [1:0] s;
    unique case (c)
      2'd0:    s = pal[1:0];
      2'd1:    s = pal[3:2];
      2'd2:    s = pal[5:4];
      default: s = pal[7:6];
    endcase
    return s;
  endfunction

  // Next state. Enables are looked at only when the sequence reaches a layer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start_i) begin
          if (bg_en_i)       state_d = StRunBg;
          else if (win_en_i) state_d = StRunWin;
          else if (obj_en_i) state_d = StRunObj;
          else               state_d = StDone;
        end
      end
      StRunBg:  if (bus.layer_done[0]) state_d = StRelBg;
      StRelBg: begin
        if (!bus.layer_done[0]) begin
          if (win_en_i)      state_d = StRunWin;
          else if (obj_en_i) state_d = StRunObj;
          else               state_d = StDone;
        end
      end
      StRunWin: if (bus.layer_done[1]) state_d = StRelWin;
      StRelWin: begin
        if (!bus.layer_done[1]) begin
          if (obj_en_i) state_d = StRunObj;
          else          state_d = StDone;
        end
      end
      StRunObj: if (bus.layer_done[2]) state_d = StRelObj;
      StRelObj: if (!bus.layer_done[2]) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // One-hot of the layer whose RUN state is current; doubles as the start decode.
  logic [2:0] run_oh;
  assign run_oh = {state_q == StRunObj, state_q == StRunWin, state_q == StRunBg};
  assign layer_start_d = run_oh;

  // Pixel fields of the running layer.
  logic [7:0] px_x, px_y;
  logic [1:0] px_c;
  always_comb begin
    px_x = bus.layer_x[7:0];
    px_y = bus.layer_y[7:0];
    px_c = bus.layer_color[1:0];
    if (run_oh[1]) begin
      px_x = bus.layer_x[15:8];
      px_y = bus.layer_y[15:8];
      px_c = bus.layer_color[3:2];
    end
    if (run_oh[2]) begin
      px_x = bus.layer_x[23:16];
      px_y = bus.layer_y[23:16];
      px_c = bus.layer_color[5:4];
    end
  end

  logic accept, in_range, transparent;
  assign accept      = |(run_oh & bus.layer_draw);
  assign in_range    = (32'(px_x) < FB_W) && (32'(px_y) < FB_H);
  assign transparent = run_oh[2] && (px_c == 2'd0);

  always_comb begin
    fb_we_d   = accept && in_range && !transparent;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    if (fb_we_d) begin
      // Modular arithmetic, so computing directly in ADDR_W bits gives the truncation.
      fb_addr_d = ADDR_W'(px_y) * ADDR_W'(FB_W) + ADDR_W'(px_x);
      fb_data_d = shade_of(run_oh[2] ? obp_i : bgp_i, px_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      layer_start_q <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      layer_start_q <= layer_start_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
    end
  end

  assign bus.layer_start = layer_start_q;
  assign bus.fb_we       = fb_we_q;
  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_data     = fb_data_q;
  assign busy_o          = (state_q != StIdle);
  assign frame_done_o    = (state_q == StDone);

endmodule

// File: tb/tb_layer_draw_sequencer.sv
module tb_layer_draw_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       frame_start;
  logic       bg_en, win_en, obj_en;
  logic [7:0] bgp, obp;
  logic       busy, frame_done;

  layer_draw_sequencer_if #(.ADDR_W(15)) bus ();

  layer_draw_sequencer #(
    .FB_W  (160),
    .FB_H  (144),
    .ADDR_W(15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start_i(frame_start),
    .bg_en_i      (bg_en),
    .win_en_i     (win_en),
    .obj_en_i     (obj_en),
    .bgp_i        (bgp),
    .obp_i        (obp),
    .bus          (bus),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Stub drawers: done rises 10 cycles into start (unless held), clears once start falls.
  logic [2:0] hold   = 3'b000;
  logic [2:0] done_r = 3'b000;
  int         cnt[3];
  assign bus.layer_done = done_r;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (bus.layer_start[i]) begin
        cnt[i]++;
        if (cnt[i] >= 10 && !hold[i]) done_r[i] = 1'b1;
      end else begin
        cnt[i] = 0;
        if (done_r[i]) done_r[i] = 1'b0;
      end
    end
  end

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_ls(input logic [2:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.layer_start === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic put_px(input int l, input logic [7:0] x, input logic [7:0] y,
                        input logic [1:0] c);
    bus.layer_draw          = 3'b001 << l;
    bus.layer_x[8*l +: 8]   = x;
    bus.layer_y[8*l +: 8]   = y;
    bus.layer_color[2*l +: 2] = c;
  endtask

  // Observes a frame already started; records distinct layer_start values.
  task automatic run_frame(input int restart_at, output logic [17:0] seq, output int n,
                           output int fd, output bit ended);
    logic [2:0] last;
    seq = '0; n = 0; fd = 0; ended = 1'b0; last = 3'b000;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      frame_start = (i == restart_at);
      if (bus.layer_start !== last) begin
        if (n < 6) seq[3*n +: 3] = bus.layer_start;
        n++;
        last = bus.layer_start;
      end
      if (frame_done) fd++;
      if (!busy) begin
        ended = 1'b1;
        break;
      end
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.layer_start, bus.fb_we, bus.fb_addr, bus.fb_data, busy, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ls=%b we=%b addr=%0d data=%0d busy=%b fd=%b want all 0",
               bus.layer_start, bus.fb_we, bus.fb_addr, bus.fb_data, busy, frame_done);
    end
  endtask

  task automatic test_full_frame();
    logic [17:0] seq;
    int n, fd;
    bit ended;
    bg_en = 1; win_en = 1; obj_en = 1;
    start_frame();
    checks++;
    if (busy !== 1'b1 || bus.layer_start !== 3'b000) begin
      errors++;
      $display("FAIL full_busy_early: got busy=%b ls=%b want busy=1 ls=000",
               busy, bus.layer_start);
    end
    run_frame(-1, seq, n, fd, ended);
    checks++;
    if (n !== 6 || seq !== {3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001}) begin
      errors++;
      $display("FAIL full_sequence: got n=%0d seq=%b want n=6 seq=000100000010000001", n, seq);
    end
    checks++;
    if (fd !== 1) begin
      errors++;
      $display("FAIL full_frame_done: got %0d pulses want 1", fd);
    end
    checks++;
    if (!ended || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_busy_end: got ended=%0d busy=%b want 1/0", ended, busy);
    end
  endtask

  task automatic test_pixels();
    bit ok;
    bit ended;
    bg_en = 1; win_en = 1; obj_en = 1;
    hold = 3'b101;
    start_frame();
    wait_ls(3'b001, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL px_bg_start: got ls=%b want 001", bus.layer_start);
    end
    bgp = 8'hE4;
    put_px(0, 8'd5, 8'd2, 2'd3);
    @(negedge clk);
    bus.layer_draw = '0;
    checks++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 15'd325 || bus.fb_data !== 2'd3) begin
      errors++;
      $display("FAIL px_bg_e4: got we=%b addr=%0d data=%0d want 1/325/3",
               bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    @(negedge clk);
    checks++;
    if (bus.fb_we !== 1'b0 || bus.fb_addr !== 15'd325 || bus.fb_data !== 2'd3) begin
      errors++;
      $display("FAIL px_one_cycle_hold: got we=%b addr=%0d data=%0d want 0/325/3",
               bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    bgp = 8'h1B;
    put_px(0, 8'd5, 8'd2, 2'd3);
    @(negedge clk);
    bus.layer_draw = '0;
    checks++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 15'd325 || bus.fb_data !== 2'd0) begin
      errors++;
      $display("FAIL px_bg_1b: got we=%b addr=%0d data=%0d want 1/325/0",
               bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    put_px(0, 8'd160, 8'd0, 2'd1);
    @(negedge clk);
    bus.layer_draw = '0;
    checks++;
    if (bus.fb_we !== 1'b0) begin
      errors++;
      $display("FAIL px_reject_x160: got we=%b want 0", bus.fb_we);
    end
    put_px(0, 8'd0, 8'd144, 2'd1);
    @(negedge clk);
    bus.layer_draw = '0;
    checks++;
    if (bus.fb_we !== 1'b0) begin
      errors++;
      $display("FAIL px_reject_y144: got we=%b want 0", bus.fb_we);
    end
    put_px(2, 8'd1, 8'd1, 2'd1);
    @(negedge clk);
    put_px(1, 8'd2, 8'd2, 2'd2);
    @(negedge clk);
    bus.layer_draw = '0;
    checks++;
    if (bus.fb_we !== 1'b0 || bus.fb_addr !== 15'd325) begin
      errors++;
      $display("FAIL px_reject_inactive: got we=%b addr=%0d want 0/325", bus.fb_we, bus.fb_addr);
    end
    hold[0] = 1'b0;
    wait_ls(3'b100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL px_obj_start: got ls=%b want 100", bus.layer_start);
    end
    obp = 8'h0C;
    put_px(2, 8'd10, 8'd10, 2'd0);
    @(negedge clk);
    bus.layer_draw = '0;
    checks++;
    if (bus.fb_we !== 1'b0) begin
      errors++;
      $display("FAIL px_obj_transparent: got we=%b want 0", bus.fb_we);
    end
    put_px(2, 8'd10, 8'd10, 2'd1);
    @(negedge clk);
    bus.layer_draw = '0;
    checks++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 15'd1610 || bus.fb_data !== 2'd3) begin
      errors++;
      $display("FAIL px_obj_c1: got we=%b addr=%0d data=%0d want 1/1610/3",
               bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    // Back-to-back sprite pixels on consecutive cycles.
    put_px(2, 8'd0, 8'd0, 2'd1);
    @(negedge clk);
    checks++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 15'd0 || bus.fb_data !== 2'd3) begin
      errors++;
      $display("FAIL px_b2b_first: got we=%b addr=%0d data=%0d want 1/0/3",
               bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    put_px(2, 8'd159, 8'd143, 2'd2);
    @(negedge clk);
    bus.layer_draw = '0;
    checks++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 15'd23039 || bus.fb_data !== 2'd0) begin
      errors++;
      $display("FAIL px_b2b_second: got we=%b addr=%0d data=%0d want 1/23039/0",
               bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    put_px(0, 8'd3, 8'd3, 2'd3);
    @(negedge clk);
    bus.layer_draw = '0;
    checks++;
    if (bus.fb_we !== 1'b0) begin
      errors++;
      $display("FAIL px_reject_bg_in_obj: got we=%b want 0", bus.fb_we);
    end
    hold[2] = 1'b0;
    ended = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ended = 1'b1;
        break;
      end
    end
    checks++;
    if (!ended) begin
      errors++;
      $display("FAIL px_frame_end: got busy=%b want 0 within budget", busy);
    end
  endtask

  task automatic test_win_skip();
    logic [17:0] seq;
    int n, fd;
    bit ended;
    bg_en = 1; win_en = 0; obj_en = 1;
    start_frame();
    run_frame(-1, seq, n, fd, ended);
    checks++;
    if (n !== 4 || seq[11:0] !== {3'b000, 3'b100, 3'b000, 3'b001}) begin
      errors++;
      $display("FAIL skip_sequence: got n=%0d seq=%b want n=4 seq=000100000001", n, seq[11:0]);
    end
    checks++;
    if (fd !== 1 || !ended) begin
      errors++;
      $display("FAIL skip_done: got fd=%0d ended=%0d want 1/1", fd, ended);
    end
    win_en = 1;
  endtask

  task automatic test_busy_ignore();
    logic [17:0] seq;
    int n, fd, late;
    bit ended;
    bg_en = 1; win_en = 1; obj_en = 1;
    start_frame();
    run_frame(15, seq, n, fd, ended);
    checks++;
    if (fd !== 1 || !ended || n !== 6) begin
      errors++;
      $display("FAIL busy_ignore_frame: got fd=%0d ended=%0d n=%0d want 1/1/6", fd, ended, n);
    end
    late = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || frame_done) late++;
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL busy_ignore_queued: got %0d busy cycles after frame want 0", late);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    bg_en = 1; win_en = 1; obj_en = 1;
    hold = 3'b010;
    start_frame();
    wait_ls(3'b010, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_win_start: got ls=%b want 010", bus.layer_start);
    end
    bgp = 8'hE4;
    put_px(1, 8'd7, 8'd9, 2'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.layer_draw = '0;
    checks++;
    if ({bus.layer_start, bus.fb_we, bus.fb_addr, bus.fb_data, busy, frame_done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got ls=%b we=%b addr=%0d data=%0d busy=%b fd=%b want 0",
               bus.layer_start, bus.fb_we, bus.fb_addr, bus.fb_data, busy, frame_done);
    end
    hold = 3'b000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || bus.fb_we || bus.layer_start != 3'b000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rst_mid_idle: got %0d active cycles after reset want 0", bad);
    end
  endtask

  initial begin
    reset           = 1'b1;
    frame_start     = 1'b0;
    bg_en           = 1'b1;
    win_en          = 1'b1;
    obj_en          = 1'b1;
    bgp             = 8'hE4;
    obp             = 8'h0C;
    bus.layer_draw  = '0;
    bus.layer_x     = '0;
    bus.layer_y     = '0;
    bus.layer_color = '0;
    test_reset();
    test_full_frame();
    test_pixels();
    test_win_skip();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
